// File: rtl/sqrt_pipe_ctrl_pkg.sv
// Shared state encoding and default sizing for the integer square-root
// pipeline controller and its period counter.
package sqrt_pipe_ctrl_pkg;

    localparam int unsigned DEF_ITER_CYCLES = 4;
    localparam int unsigned DEF_MAX_ITER    = 128;
    localparam int unsigned ITER_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/sqrt_period_cnt.sv
// Iteration-period counter: counts 0..ITER_CYCLES-1 while enabled and flags
// the last cycle of each period.
module sqrt_period_cnt #(
    parameter int unsigned ITER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic last_o
);

    localparam int unsigned CNT_W = (ITER_CYCLES > 1) ? $clog2(ITER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sqrt_pipe_ctrl.sv
// Sequencing controller for the 4-stage pipelined integer square-root datapath.
// Optional iteration watchdog enabled by defining SQRT_PIPE_CTRL_TIMEOUT_EN.
module sqrt_pipe_ctrl
    import sqrt_pipe_ctrl_pkg::*;
#(
    parameter int unsigned ITER_CYCLES = DEF_ITER_CYCLES,
    parameter int unsigned MAX_ITER    = DEF_MAX_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              N_i,
    output logic              wr_input_o,
    output logic              en_pipe_o,
    output logic              mux_root_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              error_o
);

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              period_last;
    logic              abortable;
    logic              start_ok;
    logic              run_last;
    logic              timeout;
    logic              cnt_clear;
    logic              cnt_en;

    assign abortable = state_q inside {ST_LOAD, ST_RUN, ST_FIX};
    assign start_ok  = (state_q == ST_IDLE) && start_i;
    // A RUN period only counts as completed when no abort overrides it.
    assign run_last  = (state_q == ST_RUN) && period_last && !abort_i;
    assign cnt_en    = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign cnt_clear = (state_d != state_q);

    sqrt_period_cnt #(
        .ITER_CYCLES (ITER_CYCLES)
    ) u_period_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .last_o  (period_last)
    );

`ifdef SQRT_PIPE_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(MAX_ITER + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_ITER - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;

    assign timeout = run_last && !N_i && (wd_q == WD_LAST);

    always_comb begin
        wd_d    = wd_q;
        error_d = error_q;
        if (start_ok) begin
            wd_d    = '0;
            error_d = 1'b0;
        end else begin
            if (run_last && !N_i && (wd_q != WD_LAST)) begin
                wd_d = wd_q + 1'b1;
            end
            if (timeout) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign timeout = 1'b0;
    assign error_o = 1'b0 && (MAX_ITER != 0);
`endif

    always_comb begin
        state_d    = state_q;
        wr_input_o = 1'b0;
        en_pipe_o  = 1'b0;
        mux_root_o = 1'b0;
        ready_o    = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                wr_input_o = 1'b1;
                en_pipe_o  = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                en_pipe_o = 1'b1;
                if (period_last && (N_i || timeout)) state_d = ST_FIX;
            end
            ST_FIX: begin
                en_pipe_o  = 1'b1;
                mux_root_o = 1'b1;
                if (period_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abortable && abort_i) state_d = ST_IDLE;
    end

    always_comb begin
        iter_d = iter_q;
        if (start_ok) begin
            iter_d = '0;
        end else if (run_last && !N_i && (iter_q != '1)) begin
            iter_d = iter_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    assign iter_o = iter_q;

endmodule

// File: doc/sqrt_pipe_ctrl.md
# sqrt_pipe_ctrl

Sequencing controller for the 4-stage pipelined integer square-root datapath. It accepts a start request and loads the 16-bit operand. It then runs the pipeline in fixed-length iteration periods, watching the datapath's N flag, and applies the final root-correction period. It finishes with a one-cycle ready/done pulse. It sits between the requesting logic and the datapath's control inputs (`wr_input`, `en_pipe`, `mux_root`, `ready`) and its N flag.

## Interface
- `ITER_CYCLES`, default 4: clock cycles per iteration; equals the datapath feedback-loop latency, minimum 2.
- `MAX_ITER`, default 128: iteration limit; used only when the watchdog is compiled in.
- `clk`  in  1: single clock. One clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous and active-high.
- `start_i`  in  1: request a computation. Accepted only in IDLE; ignored otherwise.
- `abort_i`  in  1: cancel the current computation. Effective in LOAD, RUN and FIX.
- `N_i`  in  1: datapath flag, high when operand < current square.
- `wr_input_o`  out  1: datapath operand-register write enable.
- `en_pipe_o`  out  1: datapath pipeline-register enable.
- `mux_root_o`  out  1: datapath root-adder select; 1 selects the correction step.
- `ready_o`  out  1: datapath ready input; captured by the datapath's last stage.
- `busy_o`  out  1: high in every state except IDLE.
- `done_o`  out  1: one-cycle pulse; the datapath root output is valid in that cycle.
- `iter_o`  out  8: number of completed RUN periods; held after DONE until the next accepted start.
- `error_o`  out  1: watchdog timeout, sticky until the next accepted start.

## Operation
- States:
  - IDLE, LOAD, RUN, FIX, DONE.
  - Encoding lives in the package.
- Transitions:
  - IDLE: `start_i` → LOAD.
  - LOAD: always → RUN after 1 cycle.
  - RUN: `N_i` sampled high on the last cycle of a period → FIX; otherwise RUN continues.
  - FIX: → DONE after `ITER_CYCLES` cycles.
  - DONE: → IDLE after 1 cycle.
  - `abort_i` in LOAD, RUN or FIX → IDLE.
- Outputs by state:
  - IDLE: all control outputs 0.
  - LOAD: `wr_input_o`=1, `en_pipe_o`=1.
  - RUN: `en_pipe_o`=1.
  - FIX: `en_pipe_o`=1, `mux_root_o`=1.
  - DONE: `en_pipe_o`=0, `ready_o`=1, `done_o`=1.
  - `busy_o` is 1 in LOAD, RUN, FIX and DONE.
- Period counter:
  - Width is ceil(log2(`ITER_CYCLES`)).
  - Cleared on entry to RUN and FIX; counts 0..`ITER_CYCLES`-1 and wraps.
  - `N_i` is examined only when the counter equals `ITER_CYCLES`-1; all other values are ignored.
- `iter_o`:
  - Increments on each RUN period ending with `N_i`=0.
  - Saturates at 255; no wrap.
  - Cleared on an accepted start.
- Simultaneous events:
  - `abort_i` has priority over `N_i` and over period completion.
  - `start_i` in the same cycle as `abort_i` is ignored; a fresh start is accepted from IDLE on a later cycle.
  - `start_i` during DONE is ignored.
- Reset:
  - Any state → IDLE at the next edge.
  - All outputs 0, counters 0, `error_o` 0.
  - Identical behaviour mid-computation.

## Timing
- Start sampled at edge k: LOAD occupies cycle k+1, and RUN begins at cycle k+2.
- With n RUN periods ending in `N_i`=0 before the terminating period:
  - FIX begins at k+2+(n+1)·`ITER_CYCLES`.
  - DONE falls at k+2+(n+2)·`ITER_CYCLES`.
- Minimum start-to-done latency (n=0, `ITER_CYCLES`=4) is 10 cycles.
- The next start is accepted in the first IDLE cycle after DONE; back-to-back throughput is one result per latency + 1 cycle.
- All outputs are registered-state decodes; there is no combinational path from `N_i` to any output.

## Configuration
- Macro: `SQRT_PIPE_CTRL_TIMEOUT_EN`.
- Defined:
  - An iteration watchdog is built.
  - When RUN completes `MAX_ITER` periods without `N_i`, the controller sets `error_o`=1 and goes to FIX.
  - FIX and DONE then proceed normally.
- Undefined:
  - No watchdog logic is built and `error_o` is tied 0.
  - RUN continues until `N_i` or `abort_i`.

## Structure
- Package `sqrt_pipe_ctrl_pkg` holds:
  - the state enum type;
  - default `ITER_CYCLES` and `MAX_ITER` constants;
  - `ITER_W`=8.
- Sub-module `sqrt_period_cnt` holds the period counter. Inputs: clear and enable. Output: last-cycle strike. Parameter: `ITER_CYCLES`.
- The FSM and the `iter_o`/watchdog counters live in the top module.

## Test plan
- N_i forced high, start at cycle 0, `ITER_CYCLES`=4 → `wr_input_o` high in cycle 1 only; FIX cycles 6–9 with `mux_root_o`=1; `done_o`/`ready_o` in cycle 10; `iter_o`=0.
- N_i high only at the third period sample, start at cycle 0 → FIX cycles 14–17, `done_o` in cycle 18, `iter_o`=2.
- abort_i at cycle 5 during RUN → IDLE at cycle 6 with all control outputs 0 and no `done_o`; a restart at cycle 7 gives LOAD in cycle 8.
- start_i held high through a full computation → exactly one LOAD per computation; second LOAD occurs the cycle after IDLE is re-entered.
- rst asserted in FIX → next cycle IDLE, all outputs 0, `iter_o`=0.
- `SQRT_PIPE_CTRL_TIMEOUT_EN` defined, `MAX_ITER`=3, N_i held 0 → `error_o`=1, FIX after 3 periods (cycle 14), `done_o` at cycle 18; `error_o` cleared on the next accepted start.
